// File: rtl/pdec_pkg.sv
// Shared types for the polar-decoder schedule sequencer: op encoding,
// sequencer FSM states and the default maximum code-length exponent.
package pdec_pkg;

    typedef enum logic [1:0] {
        OP_F    = 2'd0,
        OP_G    = 2'd1,
        OP_PSUM = 2'd2,
        OP_LEAF = 2'd3
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INITF,
        ST_LEAF,
        ST_RREQ,
        ST_RCAP,
        ST_PSUM,
        ST_G,
        ST_F,
        ST_DONE
    } state_t;

    localparam int NMAX_DEF = 14;

endpackage

// File: rtl/pdec_sched.sv
// Successive-cancellation schedule sequencer. Walks the leaves of one
// codeword, reads the per-leaf tree depth from an external ROM and issues
// the F / G / PSUM / LEAF op stream over a valid/ready handshake.
module pdec_sched
    import pdec_pkg::*;
#(
    parameter int D    = 16384,
    parameter int W    = 4,
    parameter int NMAX = $clog2(D)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           cfg_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 rom_ce,
    output logic [$clog2(D)-1:0] rom_addr,
    input  logic [W-1:0]         rom_rdata,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [1:0]           op_type,
    output logic [3:0]           op_stage,
    output logic [$clog2(D)-1:0] op_leaf
);

    localparam int AW = $clog2(D);
    localparam int DW = $clog2(NMAX + 1);
    localparam logic [4:0]  NMAX_V = 5'(NMAX);
    localparam logic [AW:0] ONE    = (AW + 1)'(1);

    state_t        state, state_next;
    logic [3:0]    n_reg, n_next;
    logic [AW-1:0] i_reg, i_next;
    logic [3:0]    s_reg, s_next;
    logic [3:0]    d_reg, d_next;
    logic          err_reg, err_next;

    logic [AW:0]   leaf_span;
    logic          last_leaf;
    logic [3:0]    d_raw;
    logic [3:0]    d_clamped;
    logic          fire;

    // Index of the final leaf is 2^n - 1; one extra bit lets n reach AW.
    assign leaf_span = (ONE << n_reg) - ONE;
    assign last_leaf = (i_reg == leaf_span[AW-1:0]);

    // Only the low DW bits of the ROM word carry depth; any depth that would
    // climb past the root is a ROM fault and is pinned to the top stage.
    assign d_raw     = 4'(rom_rdata[DW-1:0]);
    assign d_clamped = (d_raw >= n_reg) ? (n_reg - 4'd1) : d_raw;

    assign fire = op_valid && op_ready;

    // State and walk counters; async reset aborts a codeword on the spot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            n_reg   <= 4'd0;
            i_reg   <= '0;
            s_reg   <= 4'd0;
            d_reg   <= 4'd0;
            err_reg <= 1'b0;
        end else begin
            state   <= state_next;
            n_reg   <= n_next;
            i_reg   <= i_next;
            s_reg   <= s_next;
            d_reg   <= d_next;
            err_reg <= err_next;
        end
    end

    // Next-state walk plus the Moore-style op, ROM and status outputs.
    always_comb begin
        state_next = state;
        n_next     = n_reg;
        i_next     = i_reg;
        s_next     = s_reg;
        d_next     = d_reg;
        err_next   = 1'b0;

        op_valid = 1'b0;
        op_type  = OP_F;
        op_stage = 4'd0;
        op_leaf  = i_reg;
        rom_ce   = 1'b0;
        rom_addr = i_reg;
        busy     = (state != ST_IDLE);
        done     = 1'b0;
        err      = err_reg;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, cfg_n} > NMAX_V) begin
                        err_next = 1'b1;
                    end else begin
                        n_next = cfg_n;
                        i_next = '0;
                        if (cfg_n != 4'd0) begin
                            state_next = ST_INITF;
                            s_next     = cfg_n - 4'd1;
                        end else begin
                            state_next = ST_LEAF;
                        end
                    end
                end
            end
            ST_INITF: begin
                op_valid = 1'b1;
                op_type  = OP_F;
                op_stage = s_reg;
                if (fire) begin
                    if (s_reg == 4'd0) state_next = ST_LEAF;
                    else               s_next     = s_reg - 4'd1;
                end
            end
            ST_LEAF: begin
                op_valid = 1'b1;
                op_type  = OP_LEAF;
                if (fire) state_next = last_leaf ? ST_DONE : ST_RREQ;
            end
            ST_RREQ: begin
                rom_ce     = 1'b1;
                state_next = ST_RCAP;
            end
            ST_RCAP: begin
                d_next = d_clamped;
                i_next = i_reg + AW'(1);
                if (d_clamped != 4'd0) begin
                    state_next = ST_PSUM;
                    s_next     = 4'd0;
                end else begin
                    state_next = ST_G;
                end
            end
            ST_PSUM: begin
                op_valid = 1'b1;
                op_type  = OP_PSUM;
                op_stage = s_reg;
                if (fire) begin
                    if (s_reg == d_reg - 4'd1) state_next = ST_G;
                    else                       s_next     = s_reg + 4'd1;
                end
            end
            ST_G: begin
                op_valid = 1'b1;
                op_type  = OP_G;
                op_stage = d_reg;
                if (fire) begin
                    if (d_reg != 4'd0) begin
                        state_next = ST_F;
                        s_next     = d_reg - 4'd1;
                    end else begin
                        state_next = ST_LEAF;
                    end
                end
            end
            ST_F: begin
                op_valid = 1'b1;
                op_type  = OP_F;
                op_stage = s_reg;
                if (fire) begin
                    if (s_reg == 4'd0) state_next = ST_LEAF;
                    else               s_next     = s_reg - 4'd1;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pdec_sched.sv
// Directed bench for pdec_sched: models the trailing-ones depth ROM, logs
// every op handshake and compares the streams against hand-written tables.
module tb_pdec_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_n = 4'd0;
    logic        busy, done, err, rom_ce, op_valid;
    logic        op_ready = 1'b0;
    logic [13:0] rom_addr, op_leaf;
    logic [3:0]  rom_rdata = 4'd0;
    logic [1:0]  op_type;
    logic [3:0]  op_stage;

    pdec_sched dut (
        .clk(clk), .rst(rst), .start(start), .cfg_n(cfg_n),
        .busy(busy), .done(done), .err(err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_type(op_type), .op_stage(op_stage), .op_leaf(op_leaf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] trailing_ones(input logic [13:0] a);
        logic [3:0] c;
        logic       run;
        c   = 4'd0;
        run = 1'b1;
        for (int b = 0; b < 14; b++) begin
            if (run && a[b]) c = c + 4'd1;
            else             run = 1'b0;
        end
        return c;
    endfunction

    // Depth ROM model: one-cycle registered read.
    always @(posedge clk) if (rom_ce) rom_rdata <= trailing_ones(rom_addr);

    // Expected op tables, {type, stage}: F=0x0s G=0x1s PSUM=0x2s LEAF=0x30.
    logic [5:0] exp0 [1]  = '{6'h30};
    logic [5:0] exp2 [11] = '{6'h01, 6'h00, 6'h30, 6'h10, 6'h30, 6'h20,
                              6'h11, 6'h00, 6'h30, 6'h10, 6'h30};
    logic [5:0] exp3 [26] = '{6'h02, 6'h01, 6'h00, 6'h30, 6'h10, 6'h30,
                              6'h20, 6'h11, 6'h00, 6'h30, 6'h10, 6'h30,
                              6'h20, 6'h21, 6'h12, 6'h01, 6'h00, 6'h30,
                              6'h10, 6'h30, 6'h20, 6'h11, 6'h00, 6'h30,
                              6'h10, 6'h30};

    int         cyc = 0;
    logic [5:0] hs_op   [$];
    int         hs_leaf [$];
    int         hs_cyc  [$];
    int         rom_q   [$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    bit         stall_prev = 1'b0;
    logic [1:0] st_type;
    logic [3:0] st_stage;
    logic [13:0] st_leaf;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: logs handshakes, ROM reads and done pulses; checks stalled ops hold.
    always @(negedge clk) begin
        if (op_valid && op_ready) begin
            hs_op.push_back({op_type, op_stage});
            hs_leaf.push_back(int'(op_leaf));
            hs_cyc.push_back(cyc);
            $display("op type=%0d stage=%0d leaf=%0d", op_type, op_stage, op_leaf);
        end
        if (rom_ce) rom_q.push_back(int'(rom_addr));
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall_prev && !rst) begin
            chk("stall_valid", op_valid, 1);
            chk("stall_type", op_type, st_type);
            chk("stall_stage", op_stage, st_stage);
            chk("stall_leaf", op_leaf, st_leaf);
        end
        stall_prev = op_valid && !op_ready && !rst;
        st_type    = op_type;
        st_stage   = op_stage;
        st_leaf    = op_leaf;
    end

    task automatic clear_logs();
        hs_op.delete();
        hs_leaf.delete();
        hs_cyc.delete();
        rom_q.delete();
        done_cnt = 0;
    endtask

    // One codeword; optional ready toggling and a stray start while busy.
    task automatic run_cw(input int nn, input bit toggle, input bit restart);
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; cfg_n = 4'(nn); op_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_run", busy, 1);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            if (toggle) op_ready = ~op_ready;
            if (restart && k == 4) begin
                start = 1'b1; cfg_n = 4'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        op_ready = 1'b1;
        chk("done_seen", done_cnt, 1);
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);
        chk("done_single", done_cnt, 1);
    endtask

    task automatic check_stream(input int nn);
        logic [5:0] e [$];
        int lc;
        e.delete();
        if (nn == 0)      foreach (exp0[k]) e.push_back(exp0[k]);
        else if (nn == 2) foreach (exp2[k]) e.push_back(exp2[k]);
        else              foreach (exp3[k]) e.push_back(exp3[k]);
        chk("op_count", hs_op.size(), e.size());
        lc = 0;
        for (int k = 0; k < e.size() && k < hs_op.size(); k++) begin
            chk($sformatf("op%0d", k), hs_op[k], e[k]);
            if (e[k][5:4] == 2'd3) begin
                chk($sformatf("leaf%0d", k), hs_leaf[k], lc);
                lc++;
            end
        end
        chk("rom_count", rom_q.size(), (1 << nn) - 1);
        for (int k = 0; k < rom_q.size(); k++) chk("rom_addr", rom_q[k], k);
        if (hs_cyc.size() > 0) chk("done_latency", done_cyc - hs_cyc[hs_cyc.size() - 1], 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rom_ce"}, rom_ce, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_op_valid"}, op_valid, 0);
        chk({tag, "_op_type"}, op_type, 0);
        chk({tag, "_op_stage"}, op_stage, 0);
        chk({tag, "_op_leaf"}, op_leaf, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_cw(2, 1'b0, 1'b0);
        check_stream(2);

        run_cw(3, 1'b0, 1'b0);
        check_stream(3);

        run_cw(0, 1'b0, 1'b0);
        check_stream(0);

        run_cw(2, 1'b1, 1'b1);
        check_stream(2);

        // Out-of-range exponent.
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; cfg_n = 4'd15;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_valid", op_valid, 0);
        @(posedge clk); #1;
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
        chk("err_ops", hs_op.size(), 0);

        // Asynchronous reset at the first PSUM of n=3, then a clean rerun.
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; cfg_n = 4'd3; op_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (op_valid && op_type == 2'd2) break;
        end
        chk("reach_psum", op_type, 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        chk("abort_no_done", done_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_cw(3, 1'b0, 1'b0);
        check_stream(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
